// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_monitor
// Description : Passive sequence monitor for a 0..MAXV loadable up/down
//               counter. It classifies each sample as an up step, a down step,
//               a load or an illegal value. It tracks the inferred direction
//               and keeps saturating event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module count_monitor #(
  parameter int MAXV = 4,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid,
  input  logic [2:0]    y,
  output logic          dir,
  output logic          locked,
  output logic          load_seen,
  output logic          err,
  output logic [CW-1:0] ups,
  output logic [CW-1:0] downs,
  output logic [CW-1:0] loads,
  output logic [CW-1:0] errs
);

  localparam logic [2:0] c_MAXV = 3'(MAXV);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    prev_q, prev_d;
  logic          dir_q, dir_d;
  logic          load_q, load_d;
  logic          err_q, err_d;
  logic [CW-1:0] ups_q, ups_d;
  logic [CW-1:0] downs_q, downs_d;
  logic [CW-1:0] loads_q, loads_d;
  logic [CW-1:0] errs_q, errs_d;

  logic w_illegal;
  logic w_up_step;
  logic w_dn_step;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Classify the incoming sample against the previous legal sample.
  always_comb begin
    w_illegal = (y > c_MAXV);
    w_up_step = ((prev_q < c_MAXV) && (y == prev_q + 3'd1)) ||
                ((prev_q == c_MAXV) && (y == 3'd0));
    w_dn_step = ((prev_q != 3'd0) && (y == prev_q - 3'd1)) ||
                ((prev_q == 3'd0) && (y == c_MAXV));
  end

  // Next-state logic; the pulse flags default low so they last one cycle.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    dir_d   = dir_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    ups_d   = ups_q;
    downs_d = downs_q;
    loads_d = loads_q;
    errs_d  = errs_q;

    if (valid) begin
      if (w_illegal) begin
        // Illegal values drop back to IDLE without touching prev or dir.
        err_d   = 1'b1;
        errs_d  = sat_inc(errs_q);
        state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
        // The first legal sample only seeds the reference value.
        prev_d  = y;
        state_d = ST_SYNC;
      end else begin
        prev_d = y;
        if (w_up_step) begin
          ups_d   = sat_inc(ups_q);
          dir_d   = 1'b1;
          state_d = ST_UP;
        end else if (w_dn_step) begin
          downs_d = sat_inc(downs_q);
          dir_d   = 1'b0;
          state_d = ST_DOWN;
        end else begin
          loads_d = sat_inc(loads_q);
          load_d  = 1'b1;
          state_d = ST_SYNC;
        end
      end
    end
  end

  // State register with synchronous reset that takes priority over valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      prev_q  <= 3'd0;
      dir_q   <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      ups_q   <= '0;
      downs_q <= '0;
      loads_q <= '0;
      errs_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      dir_q   <= dir_d;
      load_q  <= load_d;
      err_q   <= err_d;
      ups_q   <= ups_d;
      downs_q <= downs_d;
      loads_q <= loads_d;
      errs_q  <= errs_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    dir       = dir_q;
    locked    = (state_q == ST_UP) || (state_q == ST_DOWN);
    load_seen = load_q;
    err       = err_q;
    ups       = ups_q;
    downs     = downs_q;
    loads     = loads_q;
    errs      = errs_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_monitor
// Description : Directed bench for count_monitor (MAXV=4). It includes a
//               second instance with CW=2 for the saturation case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_monitor;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [2:0] y;

  logic       dir, locked, load_seen, err;
  logic [7:0] ups, downs, loads, errs;
  logic       dir2, locked2, load2, err2;
  logic [1:0] ups2, downs2, loads2, errs2;

  int n_checks = 0;
  int n_fail   = 0;

  count_monitor #(.MAXV(4), .CW(8)) dut (
    .clk(clk), .reset(reset), .valid(valid), .y(y),
    .dir(dir), .locked(locked), .load_seen(load_seen), .err(err),
    .ups(ups), .downs(downs), .loads(loads), .errs(errs)
  );

  count_monitor #(.MAXV(4), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .valid(valid), .y(y),
    .dir(dir2), .locked(locked2), .load_seen(load2), .err(err2),
    .ups(ups2), .downs(downs2), .loads(loads2), .errs(errs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [2:0] v);
    @(negedge clk);
    valid = 1'b1;
    y     = v;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    y     = 3'd0;

    // Reset values
    do_reset();
    check("rst_dir", dir, 0);
    check("rst_locked", locked, 0);
    check("rst_load", load_seen, 0);
    check("rst_err", err, 0);
    check("rst_ups", ups, 0);
    check("rst_downs", downs, 0);
    check("rst_loads", loads, 0);
    check("rst_errs", errs, 0);

    // Up run 0,1,2,3,4,0,1 with MAXV->0 wrap
    send(3'd0);
    check("up_first_locked", locked, 0);
    check("up_first_ups", ups, 0);
    check("up_first_load", load_seen, 0);
    begin
      logic [2:0] seq [6];
      seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
      for (int i = 0; i < 6; i++) begin
        send(seq[i]);
        check("up_locked", locked, 1);
        check("up_dir", dir, 1);
        check("up_load", load_seen, 0);
        check("up_ups", ups, i + 1);
      end
    end
    idle_cycle();
    check("hold_ups", ups, 6);
    check("hold_locked", locked, 1);

    // Down run 2,1,0,4,3 including 0->MAXV wrap
    do_reset();
    send(3'd2); send(3'd1); send(3'd0); send(3'd4); send(3'd3);
    check("dn_downs", downs, 4);
    check("dn_ups", ups, 0);
    check("dn_dir", dir, 0);
    check("dn_locked", locked, 1);

    // Load in the middle of an up run
    do_reset();
    send(3'd1); send(3'd2); send(3'd3);
    check("ld_ups_pre", ups, 2);
    send(3'd0);
    check("ld_pulse", load_seen, 1);
    check("ld_loads", loads, 1);
    check("ld_locked", locked, 0);
    check("ld_dir_kept", dir, 1);
    send(3'd1);
    check("ld_after_ups", ups, 3);
    check("ld_after_locked", locked, 1);
    check("ld_after_pulse", load_seen, 0);

    // Repeated value is a load
    do_reset();
    send(3'd3); send(3'd3);
    check("rep_loads", loads, 1);
    check("rep_pulse", load_seen, 1);
    check("rep_locked", locked, 0);
    check("rep_ups", ups, 0);
    check("rep_downs", downs, 0);
    idle_cycle();
    check("rep_pulse_gone", load_seen, 0);

    // Illegal values 6 and 7, then re-seed
    do_reset();
    send(3'd1); send(3'd2);
    check("il_ups_pre", ups, 1);
    send(3'd6);
    check("il_err6", err, 1);
    check("il_errs1", errs, 1);
    check("il_locked6", locked, 0);
    check("il_dir6", dir, 1);
    send(3'd7);
    check("il_err7", err, 1);
    check("il_errs2", errs, 2);
    send(3'd0);
    check("il_reseed_err", err, 0);
    check("il_reseed_ups", ups, 1);
    check("il_reseed_locked", locked, 0);
    check("il_reseed_load", load_seen, 0);
    check("il_reseed_dir", dir, 1);
    send(3'd1);
    check("il_end_ups", ups, 2);
    check("il_end_dir", dir, 1);
    check("il_end_locked", locked, 1);

    // Saturation on the CW=2 instance
    do_reset();
    send(3'd0); send(3'd1); send(3'd2); send(3'd3); send(3'd4); send(3'd0);
    check("sat_ups2", ups2, 3);
    check("sat_ups8", ups, 5);
    check("sat_locked2", locked2, 1);

    // Reset coincident with a valid sample
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b1;
    y     = 3'd1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    valid = 1'b0;
    check("rv_ups2", ups2, 0);
    check("rv_dir2", dir2, 0);
    check("rv_locked2", locked2, 0);
    check("rv_load2", load2, 0);
    check("rv_err2", err2, 0);
    check("rv_downs2", downs2, 0);
    check("rv_loads2", loads2, 0);
    check("rv_errs2", errs2, 0);
    // Had the sample 1 been kept, 2 would be an up step
    send(3'd2);
    check("rv_next_ups", ups, 0);
    check("rv_next_locked", locked, 0);
    check("rv_next_loads", loads, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
